// File: rtl/zeroriscy_ex_ctrl.sv
// zeroriscy_ex_ctrl: EX-stage sequencer; one instruction at a time, unit ownership, kill/drain and watchdog.
// Ports: clk/rst_n (async active-low); *_en_i unit requests from ID; ex_kill_i flush;
// *_ready_* unit done strobes; *_result_i unit results; multdiv_en_o/bnn_en_o gated enables;
// unit_kill_o abort pulse; regfile_wdata_ex_o write-back data; ex_ready_o completion;
// ex_busy_o not idle; timeout_o watchdog pulse; owner_o 0=ALU,1=MD,2=LSU,3=BNN.
module zeroriscy_ex_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit RV32M          = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic        lsu_en_i,
  input  logic        bnn_en_i,
  input  logic        ex_kill_i,
  input  logic        multdiv_ready_i,
  input  logic        lsu_ready_ex_i,
  input  logic        bnn_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] multdiv_result_i,
  input  logic [31:0] bnn_result_i,
  output logic        multdiv_en_o,
  output logic        bnn_en_o,
  output logic        unit_kill_o,
  output logic [31:0] regfile_wdata_ex_o,
  output logic        ex_ready_o,
  output logic        ex_busy_o,
  output logic        timeout_o,
  output logic [1:0]  owner_o
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;
  localparam logic [7:0] LIM = 8'(TIMEOUT_CYCLES - 1);
  state_t      r_state;
  logic [1:0]  r_owner;
  logic [7:0]  r_cnt;
  logic        w_idle, w_busy, w_md_req, w_rdy, w_tmo, w_zw;
  logic [1:0]  w_sel, w_own;
  logic [31:0] w_res;
  always_comb begin
    w_idle   = r_state == S_IDLE;
    w_busy   = r_state == S_BUSY;
    w_md_req = RV32M && (mult_en_i || div_en_i);
    w_sel    = w_md_req ? 2'd1 : lsu_en_i ? 2'd2 : bnn_en_i ? 2'd3 : 2'd0;
    w_own    = w_idle ? w_sel : r_owner;
    // owner 0 (plain ALU) is always ready
    w_rdy    = w_own == 2'd1 ? multdiv_ready_i :
               w_own == 2'd2 ? lsu_ready_ex_i  :
               w_own == 2'd3 ? bnn_ready_i     : 1'b1;
    w_res    = w_own == 2'd1 ? multdiv_result_i :
               w_own == 2'd3 ? bnn_result_i     : alu_result_i;
    w_tmo    = w_busy && !ex_kill_i && !w_rdy && r_cnt == LIM;
    w_zw     = w_idle && !ex_kill_i && w_rdy && w_sel != 2'd0;
    owner_o            = w_own;
    ex_busy_o          = !w_idle;
    timeout_o          = w_tmo;
    unit_kill_o        = w_busy && (ex_kill_i || w_tmo);
    ex_ready_o         = w_idle ? !ex_kill_i && w_rdy : w_busy && !ex_kill_i && (w_rdy || w_tmo);
    regfile_wdata_ex_o = w_tmo ? 32'd0 : w_res;
    multdiv_en_o       = RV32M && w_own == 2'd1 && ((w_busy && !ex_kill_i) || w_zw);
    bnn_en_o           = w_own == 2'd3 && ((w_busy && !ex_kill_i) || w_zw);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_cnt   <= 8'd0;
    end else if (w_idle) begin
      if (!ex_kill_i && !w_rdy) begin
        r_state <= S_BUSY;
        r_owner <= w_sel;
        r_cnt   <= 8'd0;
      end
    end else if (w_busy) begin
      if (ex_kill_i) begin
        r_state <= w_rdy ? S_IDLE : S_DRAIN;
        r_cnt   <= 8'd0;
      end else if (w_rdy) begin
        r_state <= S_IDLE;
      end else if (r_cnt == LIM) begin
        r_state <= S_DRAIN;
        r_cnt   <= 8'd0;
      end else begin
        r_cnt <= r_cnt + {7'd0, r_cnt != 8'hFF};
      end
    end else begin
      // drain: wait for the killed unit, give up after another full window
      if (w_rdy || r_cnt == LIM) r_state <= S_IDLE;
      else r_cnt <= r_cnt + {7'd0, r_cnt != 8'hFF};
    end
  end
endmodule

// File: tb/tb_zeroriscy_ex_ctrl.sv
// tb_zeroriscy_ex_ctrl: directed self-checking bench for zeroriscy_ex_ctrl (TIMEOUT_CYCLES=8).
module tb_zeroriscy_ex_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        mult_en, div_en, lsu_en, bnn_en, kill, md_rdy, lsu_rdy, bnn_rdy;
  logic [31:0] alu_res, md_res, bnn_res, wdata;
  logic        md_en_o, bnn_en_o, ukill, ready, busy, tmo;
  logic [1:0]  owner;
  int          vectors = 0, errors = 0;
  zeroriscy_ex_ctrl #(.TIMEOUT_CYCLES(8), .RV32M(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .mult_en_i(mult_en), .div_en_i(div_en), .lsu_en_i(lsu_en), .bnn_en_i(bnn_en),
    .ex_kill_i(kill), .multdiv_ready_i(md_rdy), .lsu_ready_ex_i(lsu_rdy), .bnn_ready_i(bnn_rdy),
    .alu_result_i(alu_res), .multdiv_result_i(md_res), .bnn_result_i(bnn_res),
    .multdiv_en_o(md_en_o), .bnn_en_o(bnn_en_o), .unit_kill_o(ukill),
    .regfile_wdata_ex_o(wdata), .ex_ready_o(ready), .ex_busy_o(busy),
    .timeout_o(tmo), .owner_o(owner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    {mult_en, div_en, lsu_en, bnn_en, kill, md_rdy, lsu_rdy, bnn_rdy} = '0;
    alu_res = 32'h12345678; md_res = 32'h0; bnn_res = 32'h0;
    #3;
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_tmo", tmo, 0);
    chk("rst_kill", ukill, 0); chk("rst_mden", md_en_o, 0); chk("rst_bnnen", bnn_en_o, 0);
    chk("rst_owner", owner, 0); chk("rst_wdata", wdata, 32'h12345678);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step; #2;
      chk("alu_ready", ready, 1); chk("alu_wdata", wdata, 32'h12345678); chk("alu_busy", busy, 0);
    end
    // MD op, ready three cycles after request
    step; mult_en = 1; md_res = 32'h00000F00; #2;
    chk("md_c0_ready", ready, 0); chk("md_c0_owner", owner, 1); chk("md_c0_en", md_en_o, 0);
    step; #2;
    chk("md_c1_ready", ready, 0); chk("md_c1_busy", busy, 1); chk("md_c1_en", md_en_o, 1);
    step; #2;
    chk("md_c2_ready", ready, 0);
    step; md_rdy = 1; #2;
    chk("md_c3_ready", ready, 1); chk("md_c3_wdata", wdata, 32'h00000F00);
    step; mult_en = 0; md_rdy = 0; #2;
    chk("md_idle", busy, 0); chk("md_idle_ready", ready, 1);
    // priority: MD beats BNN
    step; div_en = 1; bnn_en = 1; #2;
    chk("pri_owner0", owner, 1); chk("pri_bnnen0", bnn_en_o, 0);
    step; #2;
    chk("pri_owner1", owner, 1); chk("pri_bnnen1", bnn_en_o, 0); chk("pri_mden1", md_en_o, 1);
    step; md_rdy = 1; #2;
    chk("pri_ready", ready, 1); chk("pri_bnnen2", bnn_en_o, 0);
    step; div_en = 0; bnn_en = 0; md_rdy = 0; #2;
    chk("pri_idle", busy, 0);
    // BNN kill then drain
    step; bnn_en = 1; bnn_res = 32'h00000B00; #2;
    chk("kb_c0_ready", ready, 0);
    step; #2;
    chk("kb_c1_en", bnn_en_o, 1); chk("kb_c1_owner", owner, 3);
    step; kill = 1; #2;
    chk("kb_c2_kill", ukill, 1); chk("kb_c2_en", bnn_en_o, 0); chk("kb_c2_ready", ready, 0);
    step; kill = 0; bnn_en = 0; #2;
    chk("kb_drain_busy", busy, 1); chk("kb_drain_kill", ukill, 0);
    chk("kb_drain_ready", ready, 0); chk("kb_drain_en", bnn_en_o, 0);
    step; bnn_rdy = 1; #2;
    chk("kb_drain_rdy_ready", ready, 0);
    step; bnn_rdy = 0; #2;
    chk("kb_idle", busy, 0);
    // kill with same-cycle ready goes straight to idle
    step; bnn_en = 1; #2;
    step; #2;
    chk("kr_busy", busy, 1);
    step; kill = 1; bnn_rdy = 1; #2;
    chk("kr_kill", ukill, 1); chk("kr_ready", ready, 0);
    step; kill = 0; bnn_rdy = 0; bnn_en = 0; #2;
    chk("kr_idle", busy, 0); chk("kr_kill_off", ukill, 0);
    // watchdog: 8th busy cycle times out, ready 2 cycles later leaves drain
    alu_res = 32'hAAAA5555; md_res = 32'h0BADF00D;
    step; mult_en = 1; #2;
    for (int i = 1; i <= 7; i++) begin
      step; #2;
      chk("to_pre", tmo, 0);
    end
    step; #2;
    chk("to_tmo", tmo, 1); chk("to_ready", ready, 1); chk("to_wdata", wdata, 0); chk("to_kill", ukill, 1);
    step; mult_en = 0; #2;
    chk("to_d1_tmo", tmo, 0); chk("to_d1_busy", busy, 1); chk("to_d1_ready", ready, 0); chk("to_d1_kill", ukill, 0);
    step; md_rdy = 1; #2;
    chk("to_d2_ready", ready, 0);
    step; md_rdy = 0; #2;
    chk("to_idle", busy, 0);
    // drain itself gives up after another 8 cycles
    step; mult_en = 1; #2;
    for (int i = 1; i <= 8; i++) step;
    #2; chk("dt_tmo", tmo, 1);
    step; mult_en = 0; #2;
    for (int i = 1; i <= 7; i++) begin
      chk("dt_busy", busy, 1); chk("dt_no_tmo", tmo, 0);
      step; #2;
    end
    chk("dt_busy8", busy, 1);
    step; #2;
    chk("dt_idle", busy, 0);
    // zero-wait BNN
    step; bnn_en = 1; bnn_rdy = 1; bnn_res = 32'hCAFEBABE; #2;
    chk("zw_ready", ready, 1); chk("zw_wdata", wdata, 32'hCAFEBABE); chk("zw_en", bnn_en_o, 1);
    step; bnn_en = 0; bnn_rdy = 0; #2;
    chk("zw_busy", busy, 0); chk("zw_en_off", bnn_en_o, 0);
    // LSU op: write-back takes ALU data
    step; lsu_en = 1; #2;
    step; #2;
    chk("lsu_owner", owner, 2); chk("lsu_busy", busy, 1);
    step; lsu_rdy = 1; #2;
    chk("lsu_ready", ready, 1); chk("lsu_wdata", wdata, 32'hAAAA5555);
    step; lsu_en = 0; lsu_rdy = 0; #2;
    chk("lsu_idle", busy, 0);
    // kill in idle: no acceptance
    step; mult_en = 1; kill = 1; #2;
    chk("ik_ready", ready, 0); chk("ik_en", md_en_o, 0);
    step; #2;
    chk("ik_busy", busy, 0);
    // reset mid-busy
    kill = 0;
    step; #2;
    step; #2;
    chk("rb_busy", busy, 1);
    rst_n = 0; mult_en = 0; #1;
    chk("rb_busy0", busy, 0); chk("rb_ready", ready, 1); chk("rb_kill", ukill, 0);
    step; #2;
    chk("rb_kill2", ukill, 0);
    rst_n = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
